// File: rtl/fp_pack.sv
// fp_pack: packs an unpacked float (sign, signed unbiased exponent, wide
// significand, class) into an IEEE-754 binary32 word plus RISC-V fflags.
// Flow: IDLE -> NORM -> [DENORM] -> ROUND -> DONE, one operation in flight.
// Build option FP_PACK_FAST_NORM_EN: NORM uses a leading-zero count and
// finishes in a single cycle; results are identical, only latency changes.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high. Input side: in_ready is high only in IDLE. Output side:
// out_valid stays high with out_f/out_flags stable until out_ready is seen.
module fp_pack #(
    parameter int NEXP   = 8,
    parameter int NSIG   = 23,
    parameter int NEXTRA = 4,
    parameter int SIGW   = NSIG + 1 + NEXTRA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [NEXP+1:0]      in_exp,
    input  logic [SIGW-1:0]      in_sig,
    input  logic [1:0]           in_cls,
    input  logic [1:0]           in_exc,
    input  logic [2:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NSIG+NEXP:0]   out_f,
    output logic [4:0]           out_flags,
    output logic [2:0]           dbg_state
);

    // Internal exponent is wide enough that normalization never wraps.
    localparam int EW     = NEXP + 4;
    localparam int LZW    = $clog2(SIGW);
    localparam int BIAS_I = 2 ** (NEXP - 1) - 1;

    localparam logic signed [EW-1:0] EMIN      = EW'(1 - BIAS_I);
    localparam logic signed [EW-1:0] EMIN_M1   = EW'(-BIAS_I);
    localparam logic signed [EW-1:0] EMAX      = EW'(BIAS_I);
    localparam logic signed [EW-1:0] ECOLLAPSE = EW'(1 - BIAS_I - SIGW);
    localparam logic signed [EW-1:0] EONE      = EW'(1);
    localparam logic [NEXP-1:0]      BIAS_N    = NEXP'(BIAS_I);

    localparam logic [NEXP+NSIG-1:0] INF_MAG  = {{NEXP{1'b1}}, {NSIG{1'b0}}};
    localparam logic [NEXP+NSIG-1:0] MAX_MAG  = {{(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
    localparam logic [NEXP+NSIG-1:0] ZERO_MAG = {(NEXP+NSIG){1'b0}};
    localparam logic [NEXP+NSIG:0]   QNAN     = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [1:0] CLS_FINITE = 2'b00;
    localparam logic [1:0] CLS_INF    = 2'b10;
    localparam logic [1:0] CLS_NAN    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NORM   = 3'd1,
        S_DENORM = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [SIGW-1:0]        sig_q, sig_d;
    logic [2:0]             rm_q, rm_d;
    logic [1:0]             exc_q, exc_d;
    logic                   tiny_q, tiny_d;
    logic [NSIG+NEXP:0]     f_q, f_d;
    logic [4:0]             flags_q, flags_d;

    // Round-up decision for one rounding step.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return ~sign & (g | s);
            RM_RMM:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

    logic [SIGW-1:0]      norm_sig;
    logic signed [EW-1:0] norm_exp;
    logic                 norm_done;
    logic                 norm_tiny;
    logic                 t_inc;

`ifdef FP_PACK_FAST_NORM_EN
    logic [LZW-1:0] lzc;

    // Priority encoder: the highest set bit wins, giving the leading-zero count.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SIGW; i++) begin
            if (sig_q[i]) lzc = LZW'(SIGW - 1 - i);
        end
    end

    assign norm_sig  = sig_q << lzc;
    assign norm_exp  = exp_q - EW'(lzc);
    assign norm_done = 1'b1;
`else
    assign norm_sig  = sig_q;
    assign norm_exp  = exp_q;
    assign norm_done = sig_q[SIGW-1];
`endif

    // Tininess after rounding: only exp==EMIN-1 can be rescued by a carry out.
    always_comb begin
        t_inc     = round_inc(rm_q, sign_q, norm_sig[NEXTRA], norm_sig[NEXTRA-1],
                              |norm_sig[NEXTRA-2:0]);
        norm_tiny = (norm_exp < EMIN) &&
                    !((norm_exp == EMIN_M1) && (&norm_sig[SIGW-1:NEXTRA]) && t_inc);
    end

    logic                 rnd_lsb, rnd_g, rnd_s, rnd_inc, rnd_carry;
    logic                 rnd_hidden, rnd_ovf, rnd_nx;
    logic [NSIG+1:0]      mant_sum;
    logic [NSIG:0]        mant_r;
    logic signed [EW-1:0] exp_r;
    logic [NEXP-1:0]      biased;
    logic [NEXP+NSIG-1:0] ovf_mag;

    // Rounding datapath: increment, renormalize on carry, bias, overflow pick.
    always_comb begin
        rnd_lsb    = sig_q[NEXTRA];
        rnd_g      = sig_q[NEXTRA-1];
        rnd_s      = |sig_q[NEXTRA-2:0];
        rnd_inc    = round_inc(rm_q, sign_q, rnd_lsb, rnd_g, rnd_s);
        mant_sum   = {1'b0, sig_q[SIGW-1:NEXTRA]} + {{(NSIG+1){1'b0}}, rnd_inc};
        rnd_carry  = mant_sum[NSIG+1];
        mant_r     = rnd_carry ? mant_sum[NSIG+1:1] : mant_sum[NSIG:0];
        exp_r      = exp_q + EW'(rnd_carry);
        rnd_hidden = mant_r[NSIG];
        rnd_ovf    = rnd_hidden && (exp_r > EMAX);
        rnd_nx     = rnd_g | rnd_s;
        biased     = rnd_hidden ? (exp_r[NEXP-1:0] + BIAS_N) : '0;
        case (rm_q)
            RM_RTZ:  ovf_mag = MAX_MAG;
            RM_RDN:  ovf_mag = sign_q ? INF_MAG : MAX_MAG;
            RM_RUP:  ovf_mag = sign_q ? MAX_MAG : INF_MAG;
            default: ovf_mag = INF_MAG;
        endcase
    end

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        rm_d    = rm_q;
        exc_d   = exc_q;
        tiny_d  = tiny_q;
        f_d     = f_q;
        flags_d = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = EW'($signed(in_exp));
                    sig_d  = in_sig;
                    rm_d   = (in_rm > RM_RMM) ? RM_RNE : in_rm;
                    exc_d  = in_exc;
                    tiny_d = 1'b0;
                    if ((in_cls != CLS_FINITE) || (in_sig == '0)) begin
                        state_d = S_DONE;
                        flags_d = {in_exc, 3'b000};
                        case (in_cls)
                            CLS_NAN: f_d = QNAN;
                            CLS_INF: f_d = {in_sign, INF_MAG};
                            default: f_d = {in_sign, ZERO_MAG};
                        endcase
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (!norm_done) begin
                    sig_d = sig_q << 1;
                    exp_d = exp_q - EONE;
                end else begin
                    sig_d   = norm_sig;
                    exp_d   = norm_exp;
                    tiny_d  = norm_tiny;
                    state_d = (norm_exp < EMIN) ? S_DENORM : S_ROUND;
                end
            end
            S_DENORM: begin
                if (exp_q < ECOLLAPSE) begin
                    // Everything shifts out: only the sticky bit survives.
                    sig_d   = {{(SIGW-1){1'b0}}, 1'b1};
                    exp_d   = EMIN;
                    state_d = S_ROUND;
                end else begin
                    sig_d = {1'b0, sig_q[SIGW-1:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + EONE;
                    if (exp_q + EONE == EMIN) state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                f_d     = rnd_ovf ? {sign_q, ovf_mag}
                                  : {sign_q, biased, mant_r[NSIG-1:0]};
                flags_d = {exc_q, rnd_ovf, tiny_q & rnd_nx, rnd_nx | rnd_ovf};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            rm_q    <= RM_RNE;
            exc_q   <= 2'b00;
            tiny_q  <= 1'b0;
            f_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            rm_q    <= rm_d;
            exc_q   <= exc_d;
            tiny_q  <= tiny_d;
            f_q     <= f_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_f     = f_q;
    assign out_flags = flags_q;
    assign dbg_state = state_q;

endmodule
